cla_pp_accum_seq: RTL and testbench

//  Sequencer that sums the four 24-bit partial products of a 24x24 Vedic multiply
//  (built from 12x12 blocks) into a 48-bit product. It uses ONE shared 24-bit

---
 rtl/cla_pp_accum_seq_pkg.sv | 16 +
 rtl/cla_pp_accum_seq_cla.sv | 37 +++
 rtl/cla_pp_accum_seq.sv | 126 ++++++++++++
 tb/tb_cla_pp_accum_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pp_accum_seq_pkg.sv
// Shared definitions for the partial-product accumulation sequencer.
package cla_pp_accum_seq_pkg;

  localparam int W  = 24;      // shared adder / partial-product width (fixed)
  localparam int H  = W / 2;   // column shift between partial products
  localparam int PW = 2 * W;   // final product width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MID  = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/cla_pp_accum_seq_cla.sv
// 24-bit carry-lookahead adder: six 4-bit lookahead groups, group carries
// chained through group generate/propagate terms.
module FA_lookahead_24bit (
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        cin,
  output logic [23:0] sum,
  output logic        cout
);

  logic [23:0] g;
  logic [23:0] p;
  logic [23:0] c;
  logic [6:0]  gc;

  // Per-bit generate/propagate, in-group lookahead carries, group carry chain.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = '0;
    gc[0] = cin;
    for (int k = 0; k < 6; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[6];
  end

endmodule

// File: rtl/cla_pp_accum_seq.sv
// Sums the four 24-bit partial products of a 24x24 multiply into a 48-bit
// product in three passes through one shared 24-bit CLA:
//   MID : T,c1  = LH + HL
//   LOW : P[35:12],c2 = {HH[11:0],LL[23:12]} + T ; P[11:0] = LL[11:0]
//   HIGH: P[47:36] = HH[23:12] + c1 + c2
//
// Handshake: a transfer occurs on an edge where valid & ready are both high.
// The producer holds valid and data until then; ready never depends on valid.
// in_ready is combinational from out_ready (a product leaving DONE frees the
// slot in the same cycle) and is forced low while rst is high.
module cla_pp_accum_seq
  import cla_pp_accum_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  pp_ll,
  input  logic [W-1:0]  pp_lh,
  input  logic [W-1:0]  pp_hl,
  input  logic [W-1:0]  pp_hh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          busy,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [W-1:0]  ll_q, lh_q, hl_q, hh_q;
  logic [W-1:0]  t_q;
  logic          c1_q, c2_q;
  logic [PW-1:0] prod_q;

  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          accept;

  assign in_ready  = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  // Only a finished product is ever visible on the output.
  assign product   = (state_q == ST_DONE) ? prod_q : '0;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_MID;
      ST_MID:  state_d = ST_LOW;
      ST_LOW:  state_d = ST_HIGH;
      ST_HIGH: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = in_valid ? ST_MID : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Adder operand mux, driven only by state; idle states hold the adder at zero.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      ST_MID: begin
        add_a = lh_q;
        add_b = hl_q;
      end
      ST_LOW: begin
        add_a = {hh_q[H-1:0], ll_q[W-1:H]};
        add_b = t_q;
      end
      ST_HIGH: begin
        add_a   = {{H{1'b0}}, hh_q[W-1:H]};
        add_b   = {{(W-1){1'b0}}, c1_q};
        add_cin = c2_q;
      end
      default: ;
    endcase
  end

  FA_lookahead_24bit u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State, operand latches and per-pass result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ll_q    <= '0;
      lh_q    <= '0;
      hl_q    <= '0;
      hh_q    <= '0;
      t_q     <= '0;
      c1_q    <= 1'b0;
      c2_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ll_q <= pp_ll;
        lh_q <= pp_lh;
        hl_q <= pp_hl;
        hh_q <= pp_hh;
      end
      case (state_q)
        ST_MID: begin
          t_q  <= add_sum;
          c1_q <= add_cout;
        end
        ST_LOW: begin
          prod_q[W+H-1:0] <= {add_sum, ll_q[H-1:0]};
          c2_q            <= add_cout;
        end
        ST_HIGH: prod_q[PW-1:W+H] <= add_sum[H-1:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_pp_accum_seq.sv
// Bench for the partial-product accumulation sequencer.
module tb_cla_pp_accum_seq;
  import cla_pp_accum_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready;
  logic [23:0]   pp_ll, pp_lh, pp_hl, pp_hh;
  logic          out_valid, out_ready;
  logic [47:0]   product;
  logic          busy;
  state_e        dbg_state;

  int total = 0;
  int bad   = 0;
  logic [47:0] exp_q[$];

  cla_pp_accum_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_ll     (pp_ll),
    .pp_lh     (pp_lh),
    .pp_hl     (pp_hl),
    .pp_hh     (pp_hh),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [47:0] ref_sum(input logic [23:0] ll, lh, hl, hh);
    logic [47:0] r;
    r = 48'(ll) + ((48'(lh) + 48'(hl)) << 12) + (48'(hh) << 24);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [23:0] ll, lh, hl, hh);
    in_valid = 1'b1;
    pp_ll = ll; pp_lh = lh; pp_hl = hl; pp_hh = hh;
    tick();
    in_valid = 1'b0;
    pp_ll = 24'($urandom()); pp_lh = 24'($urandom());
    pp_hl = 24'($urandom()); pp_hh = 24'($urandom());
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    pp_ll = '0; pp_lh = '0; pp_hl = '0; pp_hh = '0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (product !== 48'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=IDLE", dbg_state); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_zero();
    int n;
    send_op(24'h0, 24'h0, 24'h0, 24'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b exp=1", busy); end
    wait_valid(n);
    total++; if (n != 3) begin bad++; $display("FAIL zero_latency got=%0d exp=3", n); end
    total++; if (product !== 48'h0) begin bad++; $display("FAIL zero_product got=%h exp=0", product); end
    take();
    total++; if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL zero_release got_valid=%b got_state=%0d exp=0/IDLE", out_valid, dbg_state);
    end
  endtask

  task automatic test_all_ones();
    int n;
    send_op(24'hFFE001, 24'hFFE001, 24'hFFE001, 24'hFFE001);
    wait_valid(n);
    total++; if (n != 3) begin bad++; $display("FAIL ones_latency got=%0d exp=3", n); end
    total++; if (product !== 48'hFFFFFE000001) begin bad++; $display("FAIL ones_product got=%h exp=fffffe000001", product); end
    total++; if (dut.c1_q !== 1'b1) begin bad++; $display("FAIL ones_c1 got=%b exp=1", dut.c1_q); end
    take();
  endtask

  task automatic test_single_bits();
    int n;
    logic [23:0] v [4];
    logic [47:0] e;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) v[j] = (i == j) ? 24'h1 : 24'h0;
      e = ref_sum(v[0], v[1], v[2], v[3]);
      send_op(v[0], v[1], v[2], v[3]);
      wait_valid(n);
      total++; if (product !== e) begin bad++; $display("FAIL single_bit_%0d got=%h exp=%h", i, product, e); end
      take();
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [47:0] e1, e2;
    e1 = ref_sum(24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h800001);
    e2 = ref_sum(24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h7FFFFF);
    send_op(24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h800001);
    wait_valid(n);
    in_valid = 1'b1;
    pp_ll = 24'hFFFFFF; pp_lh = 24'h000001; pp_hl = 24'hFFFFFF; pp_hh = 24'h7FFFFF;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_%0d got=%b exp=1", i, out_valid); end
      total++; if (product !== e1) begin bad++; $display("FAIL stall_product_%0d got=%h exp=%h", i, product, e1); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready_%0d got=%b exp=0", i, in_ready); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || dbg_state !== ST_MID) begin
      bad++; $display("FAIL b2b_accept got_valid=%b got_state=%0d exp=0/MID", out_valid, dbg_state);
    end
    wait_valid(n);
    total++; if (n != 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", n); end
    total++; if (product !== e2) begin bad++; $display("FAIL b2b_product got=%h exp=%h", product, e2); end
    take();
  endtask

  task automatic test_reset_mid();
    int n;
    send_op(24'hABCDEF, 24'h123456, 24'h654321, 24'hFEDCBA);
    tick();
    total++; if (dbg_state !== ST_LOW) begin bad++; $display("FAIL rmid_in_low got=%0d exp=LOW", dbg_state); end
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rmid_state got=%0d exp=IDLE", dbg_state); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
    total++; if (product !== 48'h0) begin bad++; $display("FAIL rmid_product got=%h exp=0", product); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    send_op(24'h1, 24'h0, 24'h0, 24'h0);
    wait_valid(n);
    total++; if (product !== 48'h1) begin bad++; $display("FAIL rmid_next_product got=%h exp=1", product); end
    take();
  endtask

  task automatic test_random();
    int ops_in = 0, ops_out = 0, cyc = 0;
    bit holding = 1'b0;
    logic [23:0] a, b;
    logic [47:0] cur_exp = '0, e;
    while (ops_out < 2000 && cyc < 60000) begin
      if (!holding) in_valid = 1'b0;
      if (!holding && ops_in < 2000 && $urandom_range(0, 3) != 0) begin
        a = 24'($urandom()); b = 24'($urandom());
        pp_ll = {12'h0, a[11:0]}  * {12'h0, b[11:0]};
        pp_lh = {12'h0, a[11:0]}  * {12'h0, b[23:12]};
        pp_hl = {12'h0, a[23:12]} * {12'h0, b[11:0]};
        pp_hh = {12'h0, a[23:12]} * {12'h0, b[23:12]};
        cur_exp = {24'h0, a} * {24'h0, b};
        in_valid = 1'b1;
        holding = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (dbg_state == ST_HIGH) begin
        total++; if (dut.add_sum[23:12] !== 12'h0 || dut.add_cout !== 1'b0) begin
          bad++; $display("FAIL rnd_high_adder got_sum_hi=%h got_cout=%b exp=0/0", dut.add_sum[23:12], dut.add_cout);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected_output got=%h exp=none", product);
        end else begin
          e = exp_q.pop_front();
          if (product !== e) begin bad++; $display("FAIL rnd_product op=%0d got=%h exp=%h", ops_out, product, e); end
        end
        ops_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        ops_in++;
        holding = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (ops_out != 2000) begin bad++; $display("FAIL rnd_timeout got=%0d exp=2000", ops_out); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_zero();
    test_all_ones();
    test_single_bits();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
